// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register offsets,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_pkg;

    // Word offsets as decoded from addr[3:2]
    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int EN_BIT    = 0;
    localparam int MODE_LSB  = 1;
    localparam int IM_BIT    = 3;
    localparam int PRESC_LSB = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Count-rate divider for the timer; built only when TIMER_PRESCALE_EN is defined.
// tick is high on the cycle the divider has reached limit, after which it wraps to 0.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [PRESC_W-1:0] limit,
    output logic               tick
);

    logic [PRESC_W-1:0] div;

    // >= keeps the divider bounded if limit is lowered by a write mid-count
    assign tick = (div >= limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (clr || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// Programmable down-counter timer with one-shot / auto-reload modes and a maskable,
// level-held interrupt. Optional prescaler in CTRL[4+:PRESC_W] under TIMER_PRESCALE_EN.
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0,
    parameter int          PRESC_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    timer_state_t       state;
    logic               en;
    logic               im;
    logic               pend;
    logic [1:0]         mode;
    logic [31:0]        preset;
    logic [31:0]        count;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [1:0]         reg_sel;
    logic               ctrl_wr;
    logic               preset_wr;
    logic               unused_bits;

    assign reg_sel   = addr[3:2];
    assign ctrl_wr   = we && (reg_sel == CTRL_OFF);
    assign preset_wr = we && (reg_sel == PRESET_OFF);

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (state != CNT),
        .limit(presc),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (ctrl_wr) begin
            presc <= din[PRESC_LSB +: PRESC_W];
        end
    end

    assign unused_bits = ^{addr[31:4], addr[1:0], din[31:PRESC_LSB+PRESC_W]};
`else
    assign presc       = '0;
    assign tick        = 1'b1;
    assign unused_bits = ^{addr[31:4], addr[1:0], din[31:PRESC_LSB]};
`endif

    // Bus writes sit after the FSM so they win over hardware EN/pend updates on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= PRESET_RST;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count <= '0;
                            pend  <= 1'b1;
                            state <= INT;
                        end
                    end
                end
                INT: begin
                    if (mode == MODE_RELOAD) pend <= 1'b0;
                    else                     en   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (ctrl_wr) begin
                en   <= din[EN_BIT];
                mode <= din[MODE_LSB +: 2];
                im   <= din[IM_BIT];
                pend <= 1'b0;
            end
            if (preset_wr) begin
                preset <= din;
                pend   <= 1'b0;
            end
        end
    end

    assign irq = pend & im;

    always_comb begin
        dout = '0;
        case (reg_sel)
            CTRL_OFF:   dout = 32'({presc, im, mode, en});
            PRESET_OFF: dout = preset;
            COUNT_OFF:  dout = count;
            default:    dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized runs
// compared against a latency/pulse-timing model of the timer.
module tb_timer_counter;

    localparam logic [31:0] CTRL_A   = 32'h0000_7F00;
    localparam logic [31:0] PRESET_A = 32'h0000_7F04;
    localparam logic [31:0] COUNT_A  = 32'h0000_7F08;
`ifdef TIMER_PRESCALE_EN
    localparam bit          PRESC_ON = 1'b1;
`else
    localparam bit          PRESC_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int check_count;
    int pass_count;

    timer_counter #(
        .PRESET_RST(32'h0),
        .PRESC_W   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // reference model: edges from the enabling CTRL write to the first irq
    function automatic int first_irq(input int n, input int p);
        int n_eff;
        int p_eff;
        n_eff = (n < 1) ? 1 : n;
        p_eff = PRESC_ON ? p : 0;
        return n_eff * (p_eff + 1) + 2;
    endfunction

    function automatic int reload_period(input int n, input int p);
        return first_irq(n, p) + 1;
    endfunction

    function automatic logic [31:0] ctrl_view(input logic [31:0] w);
        return PRESC_ON ? (w & 32'h0000_0FFF) : (w & 32'h0000_000F);
    endfunction

    // driver tasks
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic idle_timer();
        bus_write(CTRL_A, 32'h0);
        step(3);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int waited;
        bus_write(PRESET_A, 32'h40);
        bus_write(CTRL_A, 32'h9);
        rd = '0;
        waited = 0;
        while (rd != 32'h20 && waited < 200) begin
            step(1);
            bus_read(COUNT_A, rd);
            waited++;
        end
        check_count++;
        if (rd !== 32'h20) $display("FAIL reset_setup: COUNT %h, required 00000020", rd);
        else pass_count++;

        #1 reset = 1'b1;
        #1;
        check_count++;
        if (irq !== 1'b0) $display("FAIL reset_irq: irq %b, required 0", irq);
        else pass_count++;
        bus_read(COUNT_A, rd);
        check_count++;
        if (rd !== 32'h0) $display("FAIL reset_count: COUNT %h, required 00000000", rd);
        else pass_count++;
        bus_read(CTRL_A, rd);
        check_count++;
        if (rd !== 32'h0) $display("FAIL reset_ctrl: CTRL %h, required 00000000", rd);
        else pass_count++;
        bus_read(PRESET_A, rd);
        check_count++;
        if (rd !== 32'h0) $display("FAIL reset_preset: PRESET %h, required 00000000", rd);
        else pass_count++;

        @(negedge clk);
        reset = 1'b0;
        step(3);
        bus_read(COUNT_A, rd);
        check_count++;
        if (rd !== 32'h0 || irq !== 1'b0)
            $display("FAIL reset_stays_idle: COUNT %h irq %b, required 00000000 and 0", rd, irq);
        else pass_count++;
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        int lat;
        bit early;
        lat = first_irq(5, 0);
        bus_write(PRESET_A, 32'd5);
        bus_write(CTRL_A, 32'h9);
        early = 1'b0;
        for (int e = 1; e < lat; e++) begin
            step(1);
            if (irq) early = 1'b1;
        end
        check_count++;
        if (early !== 1'b0) $display("FAIL oneshot_early: irq seen before edge %0d, required none", lat);
        else pass_count++;
        step(1);
        check_count++;
        if (irq !== 1'b1) $display("FAIL oneshot_rise: irq %b at edge %0d, required 1", irq, lat);
        else pass_count++;
        step(10);
        bus_read(CTRL_A, rd);
        check_count++;
        if (irq !== 1'b1 || rd !== 32'h8)
            $display("FAIL oneshot_hold: irq %b CTRL %h, required 1 and 00000008", irq, rd);
        else pass_count++;
        bus_read(COUNT_A, rd);
        check_count++;
        if (rd !== 32'h0) $display("FAIL oneshot_count: COUNT %h, required 00000000", rd);
        else pass_count++;
        bus_write(CTRL_A, 32'h8);
        check_count++;
        if (irq !== 1'b0) $display("FAIL oneshot_ack: irq %b, required 0", irq);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_reload();
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        int first;
        int per;
        int limit;
        first = first_irq(3, 0);
        per   = reload_period(3, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(first + i * per));
        limit = first + 3 * per + 2;
        bus_write(PRESET_A, 32'd3);
        bus_write(CTRL_A, 32'hB);
        for (int e = 1; e <= limit; e++) begin
            step(1);
            if (irq) obs_q.push_back(32'(e));
        end
        check_count++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL reload_count: %0d irq-high cycles, required %0d", obs_q.size(), exp_q.size());
        else pass_count++;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (i >= obs_q.size())
                $display("FAIL reload_pulse%0d: missing, required edge %0d", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i])
                $display("FAIL reload_pulse%0d: edge %0d, required %0d", i, obs_q[i], exp_q[i]);
            else pass_count++;
        end
        idle_timer();
    endtask

    task automatic test_mask();
        int lat;
        bit seen;
        lat = first_irq(5, 0);
        bus_write(PRESET_A, 32'd5);
        bus_write(CTRL_A, 32'h1);
        seen = 1'b0;
        for (int e = 1; e <= lat + 3; e++) begin
            step(1);
            if (irq) seen = 1'b1;
        end
        check_count++;
        if (seen !== 1'b0 || dut.pend !== 1'b1)
            $display("FAIL mask_pend: irq seen %b pend %b, required 0 and 1", seen, dut.pend);
        else pass_count++;
        bus_write(CTRL_A, 32'h8);
        step(2);
        check_count++;
        if (dut.pend !== 1'b0 || irq !== 1'b0)
            $display("FAIL mask_clear: pend %b irq %b, required 0 and 0", dut.pend, irq);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_preset_zero();
        int lat;
        lat = first_irq(0, 0);
        bus_write(PRESET_A, 32'd0);
        bus_write(CTRL_A, 32'h9);
        step(lat - 1);
        check_count++;
        if (irq !== 1'b0) $display("FAIL preset0_early: irq %b at edge %0d, required 0", irq, lat - 1);
        else pass_count++;
        step(1);
        check_count++;
        if (irq !== 1'b1) $display("FAIL preset0_rise: irq %b at edge %0d, required 1", irq, lat);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_preset_midrun();
        logic [31:0] rd;
        int lat;
        lat = first_irq(16, 0);
        bus_write(PRESET_A, 32'h10);
        bus_write(CTRL_A, 32'h9);
        step(5);
        bus_write(PRESET_A, 32'h100);
        step(lat - 7);
        check_count++;
        if (irq !== 1'b0) $display("FAIL midrun_early: irq %b at edge %0d, required 0", irq, lat - 1);
        else pass_count++;
        step(1);
        check_count++;
        if (irq !== 1'b1) $display("FAIL midrun_rise: irq %b at edge %0d, required 1", irq, lat);
        else pass_count++;
        bus_read(PRESET_A, rd);
        check_count++;
        if (rd !== 32'h100) $display("FAIL midrun_preset: PRESET %h, required 00000100", rd);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_pause();
        logic [31:0] rd;
        bus_write(PRESET_A, 32'h10);
        bus_write(CTRL_A, 32'h1);
        step(6);
        bus_write(CTRL_A, 32'h0);
        step(5);
        bus_read(COUNT_A, rd);
        // written on edge 7: counting ran on edges 3..7 from a load of 0x10
        check_count++;
        if (rd !== 32'(16 - 5)) $display("FAIL pause_freeze: COUNT %h, required %h", rd, 32'(16 - 5));
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_int_edge_write();
        logic [31:0] rd;
        int lat;
        lat = first_irq(4, 0);
        bus_write(PRESET_A, 32'd4);
        bus_write(CTRL_A, 32'h9);
        step(lat);
        check_count++;
        if (irq !== 1'b1) $display("FAIL intedge_entry: irq %b at edge %0d, required 1", irq, lat);
        else pass_count++;
        bus_write(CTRL_A, 32'h9);
        bus_read(CTRL_A, rd);
        check_count++;
        if (rd !== 32'h9 || dut.pend !== 1'b0 || irq !== 1'b0)
            $display("FAIL intedge_write: CTRL %h pend %b irq %b, required 00000009 0 0", rd, dut.pend, irq);
        else pass_count++;
        step(lat - 1);
        check_count++;
        if (irq !== 1'b0) $display("FAIL intedge_rerun_early: irq %b, required 0", irq);
        else pass_count++;
        step(1);
        check_count++;
        if (irq !== 1'b1) $display("FAIL intedge_rerun: irq %b, required 1", irq);
        else pass_count++;
        idle_timer();

        bus_write(PRESET_A, 32'd4);
        bus_write(CTRL_A, 32'h9);
        step(lat - 1);
        bus_write(CTRL_A, 32'h9);
        check_count++;
        if (dut.pend !== 1'b0 || irq !== 1'b0)
            $display("FAIL entry_write: pend %b irq %b, required 0 and 0", dut.pend, irq);
        else pass_count++;
        step(1);
        bus_read(CTRL_A, rd);
        check_count++;
        if (rd !== 32'h8 || irq !== 1'b0)
            $display("FAIL entry_write_en: CTRL %h irq %b, required 00000008 and 0", rd, irq);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
        int lat;
        lat = first_irq(2, 3);
        bus_write(PRESET_A, 32'd2);
        bus_write(CTRL_A, 32'h39);
        bus_read(CTRL_A, rd);
        check_count++;
        if (rd !== ctrl_view(32'h39)) $display("FAIL presc_ctrl: CTRL %h, required %h", rd, ctrl_view(32'h39));
        else pass_count++;
        step(lat - 1);
        check_count++;
        if (irq !== 1'b0) $display("FAIL presc_early: irq %b at edge %0d, required 0", irq, lat - 1);
        else pass_count++;
        step(1);
        check_count++;
        if (irq !== 1'b1) $display("FAIL presc_rise: irq %b at edge %0d, required 1", irq, lat);
        else pass_count++;
        idle_timer();
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        logic [31:0] ctrl;
        logic [31:0] rd;
        int n;
        int p;
        int mode;
        int first;
        int per;
        int limit;
        int bad;
        for (int it = 0; it < 8; it++) begin
            n     = $urandom_range(0, 12);
            p     = $urandom_range(0, 3);
            mode  = $urandom_range(0, 3);
            ctrl  = 32'h9 | 32'(mode << 1) | 32'(p << 4);
            first = first_irq(n, p);
            per   = reload_period(n, p);
            limit = first + per + 1;
            exp_q.delete();
            obs_q.delete();
            if (mode == 1) begin
                exp_q.push_back(32'(first));
                exp_q.push_back(32'(first + per));
            end else begin
                for (int e = first; e <= limit; e++) exp_q.push_back(32'(e));
            end
            bus_write(PRESET_A, 32'(n));
            bus_write(CTRL_A, ctrl);
            for (int e = 1; e <= limit; e++) begin
                step(1);
                if (irq) obs_q.push_back(32'(e));
            end
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) bad++;
            check_count++;
            if (bad != 0)
                $display("FAIL rand%0d_irq: n=%0d p=%0d mode=%0d first high edge %0d of %0d, required %0d of %0d",
                         it, n, p, mode, (obs_q.size() > 0) ? int'(obs_q[0]) : -1, obs_q.size(),
                         first, exp_q.size());
            else pass_count++;
            bus_read(CTRL_A, rd);
            check_count++;
            if (mode == 1) begin
                if (rd !== ctrl_view(ctrl))
                    $display("FAIL rand%0d_ctrl: CTRL %h, required %h", it, rd, ctrl_view(ctrl));
                else pass_count++;
            end else begin
                if (rd !== (ctrl_view(ctrl) & ~32'h1))
                    $display("FAIL rand%0d_ctrl: CTRL %h, required %h", it, rd, ctrl_view(ctrl) & ~32'h1);
                else pass_count++;
            end
            idle_timer();
        end
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        step(3);
        @(negedge clk);
        reset = 1'b0;
        step(2);

        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_preset_zero();
        test_preset_midrun();
        test_pause();
        test_int_edge_write();
        test_prescale();
        test_random();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
